// File: rtl/data_bus_responder_if.sv
// CPU data-memory bus: store strobe, byte address, store data and same-cycle load data.
// Single-cycle access with no wait states and no backpressure.
interface data_bus_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output addr, output writedata, input readdata);
    modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/data_bus_responder.sv
// Data-bus responder: word RAM at 0x0000xxxx, LED/switch/timer MMIO at 0xFFFFxxxx.
// Zero-wait-state combinational reads, writes on the rising edge; no backpressure.
module data_bus_responder #(
    parameter int RAM_AW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_bus_responder_if.slave  bus,
    input  logic [15:0]          switches,
    output logic [15:0]          leds,
    output logic                 irq
);
    localparam int RAM_WORDS = 2 ** RAM_AW;

    logic [31:0]       ram [RAM_WORDS];
    logic [15:0]       led;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic [31:0]       tcount;
    logic [31:0]       tcmp;
    logic [2:0]        tctrl;      // bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
    logic              match;

    logic              ram_sel;
    logic              mmio_sel;
    logic [2:0]        reg_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram;
    logic              wr_led;
    logic              wr_tcount;
    logic              wr_tcmp;
    logic              wr_tctrl;
    logic              wr_tstat;
    logic              match_now;
    logic              unused_addr;

    assign ram_sel     = (bus.addr[31:16] == 16'h0000);
    assign mmio_sel    = (bus.addr[31:16] == 16'hFFFF);
    assign reg_sel     = bus.addr[4:2];
    assign ram_idx     = bus.addr[RAM_AW+1:2];
    assign unused_addr = ^bus.addr;

    assign wr_ram    = bus.memwrite && ram_sel;
    assign wr_led    = bus.memwrite && mmio_sel && (reg_sel == 3'd0);
    assign wr_tcount = bus.memwrite && mmio_sel && (reg_sel == 3'd2);
    assign wr_tcmp   = bus.memwrite && mmio_sel && (reg_sel == 3'd3);
    assign wr_tctrl  = bus.memwrite && mmio_sel && (reg_sel == 3'd4);
    assign wr_tstat  = bus.memwrite && mmio_sel && (reg_sel == 3'd5);

    // A frozen timer (EN=0) never reports a match.
    assign match_now = tctrl[0] && (tcount == tcmp);

    // RAM has no reset; a store coinciding with reset assertion is dropped.
    always_ff @(posedge clk) begin
        if (reset && wr_ram) begin
            ram[ram_idx] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            tcount  <= '0;
            tcmp    <= '0;
            tctrl   <= '0;
            match   <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (wr_led)   led   <= bus.writedata[15:0];
            if (wr_tcmp)  tcmp  <= bus.writedata;
            if (wr_tctrl) tctrl <= bus.writedata[2:0];

            // CPU write beats reload, reload beats increment.
            if (wr_tcount) begin
                tcount <= bus.writedata;
            end else if (match_now && tctrl[1]) begin
                tcount <= '0;
            end else if (tctrl[0]) begin
                tcount <= tcount + 32'd1;
            end

            // A fresh match outranks a coincident write-1-to-clear.
            if (match_now) begin
                match <= 1'b1;
            end else if (wr_tstat && bus.writedata[0]) begin
                match <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (ram_sel) begin
            bus.readdata = ram[ram_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                3'd0:    bus.readdata = {16'h0000, led};
                3'd1:    bus.readdata = {16'h0000, sw_sync};
                3'd2:    bus.readdata = tcount;
                3'd3:    bus.readdata = tcmp;
                3'd4:    bus.readdata = {29'd0, tctrl};
                3'd5:    bus.readdata = {31'd0, match};
                default: bus.readdata = '0;
            endcase
        end
    end

    assign leds = led;
    assign irq  = match && tctrl[2];
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, LED/SW, timer, conflicts, reset and unmapped space.
module tb_data_bus_responder;
    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic [15:0] leds;
    logic        irq;
    int          vectors;
    int          miscompares;

    logic [31:0] exp_cnt [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    logic        exp_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    localparam logic [31:0] A_LED    = 32'hFFFF0000;
    localparam logic [31:0] A_SW     = 32'hFFFF0004;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF0008;
    localparam logic [31:0] A_TCMP   = 32'hFFFF000C;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF0010;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF0014;

    data_bus_responder_if bus();

    data_bus_responder #(.RAM_AW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .switches (switches),
        .leds     (leds),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.memwrite  = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        @(posedge clk);
        #1;
        bus.memwrite  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.addr     = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        switches      = 16'h0000;
        bus.memwrite  = 1'b0;
        bus.addr      = 32'h0;
        bus.writedata = 32'h0;
        #2;
        check("rst_leds", {16'h0, leds}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus_read("rst_tcount", A_TCOUNT, 32'h0);
        bus_read("rst_tctrl", A_TCTRL, 32'h0);

        // RAM store, alias and read-during-write
        bus_write(32'h00000010, 32'hDEADBEEF);
        bus_read("ram_rd", 32'h00000010, 32'hDEADBEEF);
        bus_read("ram_alias", 32'h00000410, 32'hDEADBEEF);
        @(negedge clk);
        bus.memwrite  = 1'b1;
        bus.addr      = 32'h00000010;
        bus.writedata = 32'h11111111;
        #1;
        check("ram_rdw_old", bus.readdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        bus_read("ram_rdw_new", 32'h00000010, 32'h11111111);

        // LED register and switch synchronizer
        bus_write(A_LED, 32'h1234ABCD);
        check("leds_out", {16'h0, leds}, 32'h0000ABCD);
        bus_read("led_rd", A_LED, 32'h0000ABCD);
        @(negedge clk);
        switches = 16'h00F0;
        bus.addr = A_SW;
        @(posedge clk);
        #1;
        check("sw_1edge", bus.readdata, 32'h0);
        @(posedge clk);
        #1;
        check("sw_2edge", bus.readdata, 32'h000000F0);

        // Timer with autoreload and interrupt
        bus_write(A_TCMP, 32'd3);
        bus_write(A_TCTRL, 32'h7);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            peek($sformatf("tcount_%0d", i), A_TCOUNT, exp_cnt[i]);
            check($sformatf("irq_%0d", i), {31'h0, irq}, {31'h0, exp_irq[i]});
        end
        peek("tstat_set", A_TSTAT, 32'h1);
        bus_write(A_TSTAT, 32'h1);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // CPU write beats increment; match beats clear
        bus_write(A_TCOUNT, 32'd100);
        peek("tcount_wr_prio", A_TCOUNT, 32'd100);
        bus_write(A_TCOUNT, 32'd3);
        bus_write(A_TSTAT, 32'h1);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        peek("tstat_set_wins", A_TSTAT, 32'h1);
        peek("tcount_reload", A_TCOUNT, 32'h0);

        // Freeze with EN=0
        bus_write(A_TCTRL, 32'h6);
        peek("tcount_frozen_a", A_TCOUNT, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        peek("tcount_frozen_b", A_TCOUNT, 32'd1);
        check("irq_frozen", {31'h0, irq}, 32'h1);

        // Reset asserted mid-run, with a write attempted during reset
        bus_write(A_TCOUNT, 32'd50);
        bus_write(A_TCTRL, 32'h7);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        peek("pre_rst_tcount", A_TCOUNT, 32'd50);
        reset = 1'b0;
        #1;
        check("midrst_leds", {16'h0, leds}, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        peek("midrst_tcount", A_TCOUNT, 32'h0);
        peek("midrst_sw", A_SW, 32'h0);
        bus.memwrite  = 1'b1;
        bus.addr      = A_LED;
        bus.writedata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_leds", {16'h0, leds}, 32'h0);
        peek("postrst_tcount", A_TCOUNT, 32'h0);
        peek("postrst_tctrl", A_TCTRL, 32'h0);

        // Unmapped reads and writes
        bus_write(32'h00000000, 32'hA5A5A5A5);
        bus_read("unm_rd_hi", 32'h80000000, 32'h0);
        bus_read("unm_rd_sel6", 32'hFFFF0018, 32'h0);
        bus_write(32'h80000000, 32'hFFFFFFFF);
        bus_write(32'hFFFF0018, 32'hFFFFFFFF);
        bus_read("unm_ram0", 32'h00000000, 32'hA5A5A5A5);
        bus_read("unm_ram10", 32'h00000010, 32'h11111111);
        bus_read("unm_led", A_LED, 32'h0);
        bus_read("unm_tcmp", A_TCMP, 32'h0);
        bus_read("unm_tctrl", A_TCTRL, 32'h0);
        bus_read("unm_tstat", A_TSTAT, 32'h0);
        bus_read("unm_tcount", A_TCOUNT, 32'h0);
        bus_read("unm_sw", A_SW, 32'h000000F0);
        check("unm_irq", {31'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, meaning RAM word-address width (2^RAM_AW words of 32 bits).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port memwrite, input, 1, store strobe from the CPU memory stage.
REQ-005 SHALL have port addr, input, 32, byte address from the CPU memory stage.
REQ-006 SHALL have port writedata, input, 32, store data.
REQ-007 SHALL have port readdata, output, 32, load data returned to the CPU.
REQ-008 SHALL have port switches, input, 16, asynchronous board switches.
REQ-009 SHALL have port leds, output, 16, LED register contents.
REQ-010 SHALL have port irq, output, 1, timer interrupt request.

Function
REQ-011 SHALL decode RAM when addr[31:16]==16'h0000, word index addr[RAM_AW+1:2]; higher bits alias.
REQ-012 SHALL decode MMIO when addr[31:16]==16'hFFFF, register select addr[4:2]; addr[1:0] always ignored.
REQ-013 SHALL map MMIO: 0 LED (RW, bits 15:0), 1 SW (RO), 2 TCOUNT (RW), 3 TCMP (RW), 4 TCTRL (RW, bit0 EN, bit1 AUTORELOAD, bit2 IRQEN), 5 TSTAT (bit0 MATCH, write-1-to-clear).
REQ-014 SHALL return 0 on readdata for unmapped addresses and select values 6-7; writes there have no effect.
REQ-015 SHALL drive readdata combinationally from addr and current state, zero wait states, matching the CPU's same-cycle load.
REQ-016 SHALL perform writes only at a rising clk edge with memwrite=1; read during a write returns the pre-write value.
REQ-017 SHALL return zero-extended 16-bit values for LED and SW reads; unused TCTRL/TSTAT bits read 0 and ignore writes.
REQ-018 SHALL pass switches through a two-flop synchronizer; SW reads reflect a change after exactly 2 rising edges.
REQ-019 SHALL increment TCOUNT by 1 per cycle while EN=1, wrapping 32'hFFFFFFFF to 0.
REQ-020 SHALL set MATCH at the edge where EN=1 and TCOUNT==TCMP; with AUTORELOAD=1 TCOUNT loads 0 at that edge, else it increments.
REQ-021 SHALL give a CPU write to TCOUNT priority over increment and reload in the same cycle.
REQ-022 SHALL keep MATCH set when a match and a write-1 clear occur in the same cycle (set wins).
REQ-023 SHALL drive irq = MATCH & IRQEN, combinational from registers.
REQ-024 SHALL write TCTRL EN=0 to freeze TCOUNT at its current value; no match is detected while frozen.

Reset
REQ-025 SHALL, while reset=0, asynchronously clear LED, TCOUNT, TCMP, TCTRL, MATCH and both synchronizer stages; leds=0, irq=0.
REQ-026 SHALL NOT reset RAM contents; RAM is undefined until written.
REQ-027 SHALL, on reset assertion mid-count or mid-write, discard the in-flight write and restart all registers from 0.

Verification
REQ-028 RAM: write 32'hDEADBEEF to 0x00000010, read 0x00000010 and alias 0x00000410 (RAM_AW=8) -> both 32'hDEADBEEF; same-cycle read during write -> old value.
REQ-029 LED/SW: write 32'h1234ABCD to 0xFFFF0000 -> leds=16'hABCD, read 32'h0000ABCD; switches 0->16'h00F0 -> SW read 0 after 1 edge, 16'h00F0 after 2.
REQ-030 Timer autoreload: TCMP=3, TCTRL=3'b111 -> TCOUNT 0,1,2,3,0; MATCH and irq high from the edge after count 3; write 1 to 0xFFFF0014 -> irq low next cycle.
REQ-031 Conflicts: write TCOUNT=100 while EN=1 -> next read 100 (not 101); write-1 clear coincident with match -> MATCH stays 1.
REQ-032 Reset mid-run: reset low while TCOUNT=50, irq=1 -> immediately leds=0, irq=0, TCOUNT read 0, and it stays 0 after reset release until EN is written.
REQ-033 Unmapped: read 0x80000000 and 0xFFFF0018 -> 0; write 0xFFFFFFFF to them -> no register or RAM location changes.
